// File: rtl/song_player.sv
// Plays a 28-note song snapshot: each note sounds NOTE_CYCLES clocks followed
// by GAP_CYCLES of silence, with pause, stop and restart control.
module song_player #(
  parameter int unsigned NOTE_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 2_500_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [111:0] song_packed,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  output logic [3:0]   note,
  output logic [4:0]   note_idx,
  output logic         playing,
  output logic         done
);

  localparam int unsigned NUM_NOTES = 28;
  localparam int unsigned NOTE_W    = 4;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned SONG_W    = NUM_NOTES * NOTE_W;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NOTES - 1);
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, PLAY, GAP, PAUSED, DONE} state_t;

  state_t              state;
  state_t              ret_state;
  logic [CNT_W-1:0]    cnt;
  logic [SONG_W-1:0]   snap;

  logic [IDX_W-1:0]    idx_inc_c;
  logic [NOTE_W-1:0]   note_cur_c;
  logic [NOTE_W-1:0]   note_inc_c;

  // Nibble lookups for the current and following note of the snapshot.
  always_comb begin
    idx_inc_c  = note_idx + IDX_W'(1);
    note_cur_c = snap[{note_idx, 2'b00} +: NOTE_W];
    note_inc_c = snap[{idx_inc_c, 2'b00} +: NOTE_W];
  end

  // Playback FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ret_state <= IDLE;
      cnt       <= '0;
      snap      <= '0;
      note      <= '0;
      note_idx  <= '0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        cnt      <= '0;
        note     <= '0;
        note_idx <= '0;
        playing  <= 1'b0;
      end else if (start) begin
        snap     <= song_packed;
        state    <= PLAY;
        cnt      <= '0;
        note     <= song_packed[NOTE_W-1:0];
        note_idx <= '0;
        playing  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            playing <= 1'b0;
          end
          PLAY: begin
            if (pause) begin
              ret_state <= PLAY;
              state     <= PAUSED;
              note      <= '0;
            end else if (cnt == NOTE_LAST) begin
              cnt <= '0;
              if (GAP_CYCLES == 0) begin
                // No gap configured: apply the end-of-gap advance directly.
                if (note_idx == LAST_IDX) begin
                  state   <= DONE;
                  note    <= '0;
                  playing <= 1'b0;
                  done    <= 1'b1;
                end else begin
                  note_idx <= idx_inc_c;
                  note     <= note_inc_c;
                end
              end else begin
                state <= GAP;
                note  <= '0;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          GAP: begin
            if (pause) begin
              ret_state <= GAP;
              state     <= PAUSED;
            end else if (cnt == GAP_LAST) begin
              cnt <= '0;
              if (note_idx == LAST_IDX) begin
                state   <= DONE;
                playing <= 1'b0;
                done    <= 1'b1;
              end else begin
                state    <= PLAY;
                note_idx <= idx_inc_c;
                note     <= note_inc_c;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          PAUSED: begin
            // Counter stays frozen; resume exactly where the count stopped.
            if (!pause) begin
              state <= ret_state;
              note  <= (ret_state == PLAY) ? note_cur_c : '0;
            end
          end
          DONE: begin
            state   <= IDLE;
            note    <= '0;
            playing <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            note    <= '0;
            playing <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_player.sv
// Directed bench for song_player: a NOTE=4/GAP=2 instance and a GAP=0 instance.
module tb_song_player;

  logic         clk;
  logic         rst_n;
  logic [111:0] song;
  logic         start, stop, pause;
  logic [3:0]   note, note0;
  logic [4:0]   note_idx, note_idx0;
  logic         playing, playing0, done, done0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] song_a [28] = '{1, 1, 5, 5, 6, 6, 5, 0, 4, 4, 3, 3, 2, 2,
                              1, 0, 5, 5, 4, 4, 3, 3, 2, 0, 5, 5, 4, 4};

  song_player #(.NOTE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .song_packed(song), .start(start), .stop(stop),
    .pause(pause), .note(note), .note_idx(note_idx), .playing(playing), .done(done)
  );

  song_player #(.NOTE_CYCLES(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .song_packed(song), .start(start), .stop(stop),
    .pause(pause), .note(note0), .note_idx(note_idx0), .playing(playing0), .done(done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected note k cycles after the start edge, for a given gap length.
  function automatic logic [3:0] exp_note(input int k, input int g);
    int per;
    per = 4 + g;
    if ((k % per) < 4) return song_a[k / per];
    return 4'd0;
  endfunction

  task automatic load_song();
    for (int i = 0; i < 28; i++) song[4*i +: 4] = song_a[i];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    load_song();
    #2;
    check("rst_note", note, 0);
    check("rst_idx", note_idx, 0);
    check("rst_playing", playing, 0);
    check("rst_done", done, 0);
    check("rst_playing0", playing0, 0);
    #20 rst_n = 1'b1;
    step();
    check("idle_playing", playing, 0);

    // Full song; song bus overwritten after 3 cycles must not matter.
    pulse_start();
    for (int k = 0; k <= 169; k++) begin
      if (k == 3) song = '1;
      if (k < 168) begin
        check("song_note", note, exp_note(k, 2));
        check("song_idx", note_idx, k / 6);
        check("song_playing", playing, 1);
        check("song_done", done, 0);
      end else if (k == 168) begin
        check("done_pulse", done, 1);
        check("done_idx", note_idx, 27);
        check("done_note", note, 0);
        check("done_playing", playing, 0);
      end else begin
        check("done_one_cycle", done, 0);
        check("after_done_playing", playing, 0);
      end
      if (k < 112) begin
        check("gap0_note", note0, exp_note(k, 0));
        check("gap0_idx", note_idx0, k / 4);
        check("gap0_done", done0, 0);
      end else if (k == 112) begin
        check("gap0_done_pulse", done0, 1);
        check("gap0_done_idx", note_idx0, 27);
      end else if (k == 113) begin
        check("gap0_done_one_cycle", done0, 0);
      end
      step();
    end
    load_song();

    // Pause for 5 cycles starting at counter 2 of note 3.
    pulse_start();
    for (int k = 0; k <= 175; k++) begin
      int e;
      if (k >= 21 && k <= 25) begin
        check("pause_note", note, 0);
        check("pause_idx", note_idx, 3);
        check("pause_playing", playing, 1);
        check("pause_done", done, 0);
      end else begin
        e = (k <= 20) ? k : k - 6;
        if (e < 168) begin
          check("resume_note", note, exp_note(e, 2));
          check("resume_idx", note_idx, e / 6);
          check("resume_done", done, 0);
        end else if (e == 168) begin
          check("pause_done_pulse", done, 1);
          check("pause_done_idx", note_idx, 27);
        end else begin
          check("pause_done_after", done, 0);
        end
      end
      if (k == 20) pause = 1'b1;
      if (k == 25) pause = 1'b0;
      step();
    end

    // Stop and start together mid-song: stop wins.
    pulse_start();
    for (int k = 0; k < 50; k++) step();
    check("prestop_note", note, exp_note(50, 2));
    stop  = 1'b1;
    start = 1'b1;
    step();
    stop  = 1'b0;
    start = 1'b0;
    check("stop_note", note, 0);
    check("stop_idx", note_idx, 0);
    check("stop_playing", playing, 0);
    check("stop_done", done, 0);
    for (int k = 0; k < 200; k++) begin
      check("stop_no_done", done, 0);
      check("stop_stays_idle", playing, 0);
      step();
    end

    // Asynchronous reset during the gap of note 10, then replay.
    pulse_start();
    for (int k = 0; k < 64; k++) step();
    check("pre_rst_idx", note_idx, 10);
    check("pre_rst_note", note, 0);
    check("pre_rst_playing", playing, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_idx", note_idx, 0);
    check("async_rst_playing", playing, 0);
    check("async_rst_note", note, 0);
    check("async_rst_done", done, 0);
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    step();
    check("post_rst_idle", playing, 0);
    check("post_rst_note", note, 0);
    pulse_start();
    for (int k = 0; k < 12; k++) begin
      check("replay_note", note, exp_note(k, 2));
      check("replay_idx", note_idx, k / 6);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 Parameter NOTE_CYCLES, default 25_000_000, clk cycles each note sounds (>=1).
REQ-002 Parameter GAP_CYCLES, default 2_500_000, silent clk cycles after each note (0 = no gap).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 song_packed  input  112  28 four-bit note codes from the song library; note i = bits [4i+3:4i], note 0 plays first.
REQ-006 start  input  1  level-sampled request to begin playback from note 0.
REQ-007 stop  input  1  level-sampled request to abort playback.
REQ-008 pause  input  1  level; high holds playback, low resumes.
REQ-009 note  output  4  current note code to tone generator; 0 = silence.
REQ-010 note_idx  output  5  index 0..27 of current note.
REQ-011 playing  output  1  high in PLAY, GAP or PAUSED.
REQ-012 done  output  1  one-cycle pulse when the last note's gap completes.

Function
REQ-013 All outputs SHALL be driven from registers only; no combinational path from any input to any output.
REQ-014 FSM states SHALL be IDLE, PLAY, GAP, PAUSED, DONE.
REQ-015 IDLE/DONE with start=1 at an edge SHALL: snapshot song_packed into a 112-bit register, set note_idx=0, duration counter=0, state=PLAY; note shows snapshot nibble 0 from that edge.
REQ-016 Changes on song_packed after the snapshot SHALL NOT affect the song in progress.
REQ-017 PLAY SHALL last exactly NOTE_CYCLES cycles (counter 0..NOTE_CYCLES-1), note = snapshot nibble note_idx.
REQ-018 At end of PLAY: if GAP_CYCLES>0 go to GAP with counter=0 and note=0; else apply REQ-019 end-of-gap action directly.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles with note=0; at its end: note_idx<27 -> note_idx+1, counter=0, PLAY; note_idx=27 -> DONE.
REQ-020 DONE SHALL last one cycle with done=1, note=0, note_idx held at 27, then IDLE unless start=1 (REQ-015).
REQ-021 Song duration SHALL be 28*(NOTE_CYCLES+GAP_CYCLES) cycles from start edge to DONE entry.
REQ-022 pause=1 sampled in PLAY or GAP SHALL enter PAUSED next edge, saving the return state and freezing counter and note_idx; note=0 while PAUSED.
REQ-023 pause=0 sampled in PAUSED SHALL return to the saved state with counter resuming from its frozen value (no cycles lost or repeated).
REQ-024 stop=1 in any non-IDLE state SHALL go to IDLE next edge: note=0, note_idx=0, playing=0, no done pulse.
REQ-025 Priority at one edge: stop > start > pause; start in PLAY/GAP/PAUSED SHALL restart from note 0 with a fresh snapshot.
REQ-026 start held high SHALL NOT retrigger except via DONE->start per REQ-020/REQ-025 restart rule (level restart each edge holds note_idx=0, counter=0).
REQ-027 Duration counter SHALL be 32 bits wide; note_idx SHALL never exceed 27.
REQ-028 Note code 0 within the song SHALL be played as a rest of normal length (note=0, counting proceeds).

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, note=0, note_idx=0, playing=0, done=0, counter=0, snapshot=0, independent of clk.
REQ-030 Reset asserted mid-song SHALL abandon playback; after release block waits in IDLE for start.

Verification (NOTE_CYCLES=4, GAP_CYCLES=2)
REQ-031 song_packed nibbles 1,1,5,5,6,...; start pulse -> note=1 for 4 cycles, 0 for 2, 1 for 4, 0 for 2, 5 ...; done pulse exactly 168 cycles after start edge, note_idx=27.
REQ-032 start, then change song_packed to all-0xF after 3 cycles -> output sequence unchanged from original snapshot.
REQ-033 pause high 5 cycles at counter=2 of note 3 -> note=0 for those cycles, then note 3 resumes for remaining 2 cycles; done delayed by exactly 5+1 entry cycle +1 exit accounting as specified in REQ-022/023, checked against model.
REQ-034 stop and start high same edge mid-song -> IDLE, note=0, note_idx=0, no done.
REQ-035 rst_n low asynchronously between edges during GAP of note 10 -> outputs 0 immediately; after release, start replays from note 0.
REQ-036 GAP_CYCLES=0 build -> notes back-to-back with no silent cycles; done at 112 cycles.
